// File: rtl/pio_release_gate.sv
// pio_release_gate: holds one processor-written PIO value and forwards it to
// pio_out only when the fingerprint comparator releases it with the matching
// task key and a pass verdict. Failed, aborted or timed-out values are dropped
// and recorded in sticky status bits that drive irq.
module pio_release_gate #(
    parameter int KEY_W          = 4,
    parameter int PIO_W          = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       avs_address,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    input  logic             avs_read,
    output logic [31:0]      avs_readdata,
    input  logic             rel_valid,
    input  logic [KEY_W-1:0] rel_key,
    input  logic             rel_pass,
    output logic [PIO_W-1:0] pio_out,
    output logic             released,
    output logic             irq
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMAX = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    localparam logic [1:0] A_TASK = 2'd0;
    localparam logic [1:0] A_DATA = 2'd1;
    localparam logic [1:0] A_STAT = 2'd2;
    localparam logic [1:0] A_CTRL = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        PENDING = 2'd2
    } state_t;

    // Field order matches STATUS[7:2] so the struct drops straight into the read word.
    typedef struct packed {
        logic timeout;
        logic early;
        logic abort;
        logic fault;
        logic notask;
        logic overflow;
    } sticky_t;

    state_t             state, nxt_state;
    logic [KEY_W-1:0]   task_id, nxt_task;
    logic [PIO_W-1:0]   data_q, nxt_data;
    logic [TW-1:0]      timer, nxt_timer;
    sticky_t            sticky, nxt_sticky;
    logic [7:0]         mism_cnt, nxt_mism;
    logic [PIO_W-1:0]   nxt_pio;
    logic               nxt_rel;
    logic [31:0]        rd_mux;

    logic rel_hit, rel_miss, tmo;
    logic wr_task, wr_data, wr_ctrl;

    // Upper write-data bits carry no meaning for any register.
    logic unused_wd;
    assign unused_wd = ^avs_writedata;

    assign rel_hit  = rel_valid && (state == PENDING) && (rel_key == task_id);
    assign rel_miss = rel_valid && !rel_hit;
    assign tmo      = (TIMEOUT_CYCLES > 0) && (state == PENDING) && (timer == TMAX) && !rel_hit;
    assign wr_task  = avs_write && (avs_address == A_TASK);
    assign wr_data  = avs_write && (avs_address == A_DATA);
    assign wr_ctrl  = avs_write && (avs_address == A_CTRL);

    // Next-state: release/timeout resolved on the old state first, then any bus write layered on top.
    always_comb begin
        nxt_state  = state;
        nxt_task   = task_id;
        nxt_data   = data_q;
        nxt_timer  = timer;
        nxt_sticky = sticky;
        nxt_mism   = mism_cnt;
        nxt_pio    = pio_out;
        nxt_rel    = 1'b0;

        if (state == PENDING)
            nxt_timer = timer + TW'(1);

        if (rel_hit) begin
            nxt_state = IDLE;
            if (rel_pass) begin
                nxt_pio = data_q;
                nxt_rel = 1'b1;
            end else begin
                nxt_sticky.fault = 1'b1;
            end
        end else if (tmo) begin
            nxt_state          = IDLE;
            nxt_sticky.timeout = 1'b1;
        end

        if (rel_miss) begin
            if (mism_cnt != 8'hFF)
                nxt_mism = mism_cnt + 8'd1;
            if (state == ARMED)
                nxt_sticky.early = 1'b1;
        end

        if (wr_task) begin
            // Only a value still pending after this cycle's release is aborted.
            if (nxt_state == PENDING)
                nxt_sticky.abort = 1'b1;
            nxt_task  = avs_writedata[KEY_W-1:0];
            nxt_state = ARMED;
        end else if (wr_data) begin
            // A release this cycle frees the slot, so the new word is accepted.
            if (rel_hit || nxt_state == ARMED) begin
                nxt_data  = avs_writedata[PIO_W-1:0];
                nxt_timer = '0;
                nxt_state = PENDING;
            end else if (nxt_state == PENDING) begin
                nxt_sticky.overflow = 1'b1;
            end else begin
                nxt_sticky.notask = 1'b1;
            end
        end else if (wr_ctrl) begin
            if (avs_writedata[0]) begin
                nxt_sticky = '0;
                nxt_mism   = '0;
            end
            if (avs_writedata[1])
                nxt_state = IDLE;
        end
    end

    // Read mux; sampled into avs_readdata for fixed latency 1.
    always_comb begin
        rd_mux = '0;
        case (avs_address)
            A_TASK:  rd_mux = 32'(task_id);
            A_DATA:  rd_mux = 32'(data_q);
            A_STAT:  rd_mux = 32'({task_id, mism_cnt, sticky, state});
            default: rd_mux = '0;
        endcase
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            task_id      <= '0;
            data_q       <= '0;
            timer        <= '0;
            sticky       <= '0;
            mism_cnt     <= '0;
            pio_out      <= '0;
            released     <= 1'b0;
            irq          <= 1'b0;
            avs_readdata <= '0;
        end else begin
            state    <= nxt_state;
            task_id  <= nxt_task;
            data_q   <= nxt_data;
            timer    <= nxt_timer;
            sticky   <= nxt_sticky;
            mism_cnt <= nxt_mism;
            pio_out  <= nxt_pio;
            released <= nxt_rel;
            irq      <= |nxt_sticky;
            if (avs_read)
                avs_readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_pio_release_gate.sv
// Directed bench for pio_release_gate (TIMEOUT_CYCLES=16).
// Every task is entered on a falling edge and returns on a falling edge.
module tb_pio_release_gate;

    logic        clk;
    logic        reset;
    logic [1:0]  avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic        rel_valid;
    logic [3:0]  rel_key;
    logic        rel_pass;
    logic [3:0]  pio_out;
    logic        released;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    pio_release_gate #(.KEY_W(4), .PIO_W(4), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .avs_address(avs_address), .avs_write(avs_write), .avs_writedata(avs_writedata),
        .avs_read(avs_read), .avs_readdata(avs_readdata),
        .rel_valid(rel_valid), .rel_key(rel_key), .rel_pass(rel_pass),
        .pio_out(pio_out), .released(released), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic av_write(input logic [1:0] a, input logic [31:0] d);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    task automatic av_read(input logic [1:0] a, output logic [31:0] d);
        avs_address = a; avs_read = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    task automatic pulse_rel(input logic [3:0] k, input logic p);
        rel_valid = 1'b1; rel_key = k; rel_pass = p;
        @(negedge clk);
        rel_valid = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        checks++; if (pio_out !== 4'h0) begin failures++; $display("FAIL reset_pio got=%h exp=0", pio_out); end
        checks++; if (released !== 1'b0) begin failures++; $display("FAIL reset_released got=%b exp=0", released); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
        checks++; if (avs_readdata !== 32'h0) begin failures++; $display("FAIL reset_readdata got=%h exp=0", avs_readdata); end
        reset = 1'b0;
        @(negedge clk);
        av_read(2, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_status got=%h exp=0", d); end
    endtask

    task automatic test_release_pass;
        logic [31:0] d;
        av_write(0, 32'd3);
        av_write(1, 32'hA);
        pulse_rel(4'd3, 1'b1);
        checks++; if (pio_out !== 4'hA) begin failures++; $display("FAIL pass_pio got=%h exp=a", pio_out); end
        checks++; if (released !== 1'b1) begin failures++; $display("FAIL pass_released_hi got=%b exp=1", released); end
        @(negedge clk);
        checks++; if (released !== 1'b0) begin failures++; $display("FAIL pass_released_lo got=%b exp=0", released); end
        av_read(2, d);
        checks++; if (d !== 32'h0003_0000) begin failures++; $display("FAIL pass_status got=%h exp=00030000", d); end
    endtask

    task automatic test_mismatch_fault;
        logic [31:0] d;
        av_write(0, 32'd5);
        av_write(1, 32'h6);
        pulse_rel(4'd2, 1'b1);
        checks++; if (pio_out !== 4'hA) begin failures++; $display("FAIL mism_pio got=%h exp=a", pio_out); end
        av_read(2, d);
        checks++; if (d !== 32'h0005_0102) begin failures++; $display("FAIL mism_status got=%h exp=00050102", d); end
        pulse_rel(4'd5, 1'b0);
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL fault_irq got=%b exp=1", irq); end
        checks++; if (pio_out !== 4'hA || released !== 1'b0) begin failures++; $display("FAIL fault_pio got=%h/%b exp=a/0", pio_out, released); end
        av_read(2, d);
        checks++; if (d !== 32'h0005_0110) begin failures++; $display("FAIL fault_status got=%h exp=00050110", d); end
        av_write(3, 32'd1);
    endtask

    task automatic test_overflow;
        logic [31:0] d;
        av_write(0, 32'd1);
        av_write(1, 32'h3);
        av_write(1, 32'hC);
        av_read(2, d);
        checks++; if (d !== 32'h0001_0006) begin failures++; $display("FAIL ovf_status got=%h exp=00010006", d); end
        pulse_rel(4'd1, 1'b1);
        checks++; if (pio_out !== 4'h3) begin failures++; $display("FAIL ovf_pio got=%h exp=3", pio_out); end
        av_write(3, 32'd1);
    endtask

    task automatic test_timeout;
        logic [31:0] d;
        av_write(0, 32'd2);
        av_write(1, 32'h5);
        repeat (15) @(negedge clk);
        av_read(2, d);   // state after the 15th PENDING edge
        checks++; if (d !== 32'h0002_0002) begin failures++; $display("FAIL tmo_before got=%h exp=00020002", d); end
        av_read(2, d);   // state after the 16th PENDING edge
        checks++; if (d !== 32'h0002_0080) begin failures++; $display("FAIL tmo_after got=%h exp=00020080", d); end
        checks++; if (irq !== 1'b1 || pio_out !== 4'h3) begin failures++; $display("FAIL tmo_irq_pio got=%b/%h exp=1/3", irq, pio_out); end
        av_write(3, 32'd1);
        av_write(1, 32'h5);   // task 2 still held, state ARMED? no: IDLE -> NOTASK
        av_write(3, 32'd1);
        av_write(0, 32'd2);
        av_write(1, 32'h5);
        repeat (15) @(negedge clk);
        pulse_rel(4'd2, 1'b1);   // lands on the last allowed cycle
        checks++; if (pio_out !== 4'h5 || released !== 1'b1) begin failures++; $display("FAIL tmo_race_pio got=%h/%b exp=5/1", pio_out, released); end
        av_read(2, d);
        checks++; if (d !== 32'h0002_0000) begin failures++; $display("FAIL tmo_race_status got=%h exp=00020000", d); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d;
        av_write(0, 32'd4);
        av_write(1, 32'hE);
        rel_valid = 1'b1; rel_key = 4'd4; rel_pass = 1'b1;
        avs_address = 2'd0; avs_writedata = 32'd7; avs_write = 1'b1;
        @(negedge clk);
        rel_valid = 1'b0; avs_write = 1'b0;
        checks++; if (pio_out !== 4'hE || released !== 1'b1) begin failures++; $display("FAIL b2b_task_pio got=%h/%b exp=e/1", pio_out, released); end
        av_read(2, d);
        checks++; if (d !== 32'h0007_0001) begin failures++; $display("FAIL b2b_task_status got=%h exp=00070001", d); end
        av_write(1, 32'h2);
        rel_valid = 1'b1; rel_key = 4'd7; rel_pass = 1'b1;
        avs_address = 2'd1; avs_writedata = 32'hB; avs_write = 1'b1;
        @(negedge clk);
        rel_valid = 1'b0; avs_write = 1'b0;
        checks++; if (pio_out !== 4'h2) begin failures++; $display("FAIL b2b_data_pio got=%h exp=2", pio_out); end
        av_read(2, d);
        checks++; if (d !== 32'h0007_0002) begin failures++; $display("FAIL b2b_data_status got=%h exp=00070002", d); end
        pulse_rel(4'd7, 1'b1);
        checks++; if (pio_out !== 4'hB) begin failures++; $display("FAIL b2b_second_pio got=%h exp=b", pio_out); end
    endtask

    task automatic test_errors;
        logic [31:0] d;
        av_write(1, 32'h3);          // IDLE -> NOTASK
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL notask_irq got=%b exp=1", irq); end
        av_read(2, d);
        checks++; if (d !== 32'h0007_0008) begin failures++; $display("FAIL notask_status got=%h exp=00070008", d); end
        av_write(0, 32'd7);
        pulse_rel(4'd7, 1'b1);       // ARMED -> EARLY + mism
        av_read(2, d);
        checks++; if (d !== 32'h0007_0149) begin failures++; $display("FAIL early_status got=%h exp=00070149", d); end
        av_write(1, 32'h4);
        av_write(0, 32'd8);          // PENDING -> ABORT
        av_read(2, d);
        checks++; if (d !== 32'h0008_0169) begin failures++; $display("FAIL abort_status got=%h exp=00080169", d); end
        av_write(1, 32'h5);
        av_write(3, 32'd2);          // force IDLE, no new flag
        av_read(2, d);
        checks++; if (d !== 32'h0008_0168 || pio_out !== 4'hB) begin failures++; $display("FAIL force_idle got=%h/%h exp=00080168/b", d, pio_out); end
        av_write(3, 32'd1);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL clear_irq got=%b exp=0", irq); end
        av_read(2, d);
        checks++; if (d !== 32'h0008_0000) begin failures++; $display("FAIL clear_status got=%h exp=00080000", d); end
    endtask

    task automatic test_async_reset;
        logic [31:0] d;
        av_write(0, 32'd6);
        av_write(1, 32'h9);
        pulse_rel(4'd6, 1'b1);
        checks++; if (pio_out !== 4'h9) begin failures++; $display("FAIL ar_setup_pio got=%h exp=9", pio_out); end
        av_write(0, 32'd6);
        av_write(1, 32'h1);
        #2 reset = 1'b1;
        #1;
        checks++; if (pio_out !== 4'h0 || irq !== 1'b0) begin failures++; $display("FAIL ar_async_pio got=%h/%b exp=0/0", pio_out, irq); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        av_read(2, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL ar_status got=%h exp=0", d); end
        av_read(1, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL ar_data got=%h exp=0", d); end
    endtask

    initial begin
        reset = 1'b1;
        avs_address = '0; avs_write = 1'b0; avs_writedata = '0; avs_read = 1'b0;
        rel_valid = 1'b0; rel_key = '0; rel_pass = 1'b0;
        repeat (2) @(negedge clk);
        test_reset;
        test_release_pass;
        test_mismatch_fault;
        test_overflow;
        test_timeout;
        test_back_to_back;
        test_errors;
        test_async_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
